gfx_mem_arbiter: RTL and testbench

//  Responder end of the gfx read channel (memory_address/rvalid/rready/memory_data) used by

---
 rtl/gfx_mem_arbiter.sv | 108 ++++++++++
 tb/tb_gfx_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_mem_arbiter.sv
// rtl/gfx_mem_arbiter.sv - round-robin read arbiter for gfx engines onto a fixed-latency memory port
//
// Purpose: responder end of the gfx read channel. N_CLIENTS read initiators are
// arbitrated round-robin onto one pipelined memory read port. Each word is returned
// to its requester on the shared client_data bus with a single-cycle client_rready pulse.
//
// Ports:
//   CLK            clock, all logic on rising edge
//   RST            synchronous reset, active high
//   client_address client k word address at [k*ADDR_BITS +: ADDR_BITS]
//   client_rvalid  client k request valid (address stable while high)
//   client_rready  one-cycle pulse: client k data is on client_data
//   client_data    registered read data, shared by all clients
//   mem_address    address to memory, valid when mem_re=1
//   mem_re         memory read strobe, at most one request per cycle
//   mem_data       memory read data, valid MEM_LATENCY cycles after mem_re

module gfx_mem_arbiter #(
    parameter int N_CLIENTS   = 4,
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BITS   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [N_CLIENTS*ADDR_BITS-1:0] client_address,
    input  logic [N_CLIENTS-1:0]           client_rvalid,
    output logic [N_CLIENTS-1:0]           client_rready,
    output logic [DATA_BITS-1:0]           client_data,
    output logic [ADDR_BITS-1:0]           mem_address,
    output logic                           mem_re,
    input  logic [DATA_BITS-1:0]           mem_data
);

    localparam int TAG_BITS = $clog2(N_CLIENTS);

    logic [N_CLIENTS-1:0] pending;
    logic [TAG_BITS-1:0]  rr_ptr;
    logic [N_CLIENTS-1:0] eligible;
    logic                 grant_found;
    logic [TAG_BITS-1:0]  grant_idx;
    logic [TAG_BITS-1:0]  cand_idx;
    logic [TAG_BITS-1:0]  next_rr;
    logic [N_CLIENTS-1:0] grant_onehot;

    // Tag pipe: tracks which client owns the word arriving on mem_data.
    logic [MEM_LATENCY-1:0] pipe_valid;
    logic [TAG_BITS-1:0]    pipe_tag [MEM_LATENCY];

    // A client with a read outstanding (including its rready cycle) cannot be granted.
    assign eligible = client_rvalid & ~pending;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cand_idx = TAG_BITS'((int'(rr_ptr) + i) % N_CLIENTS);
            if (!grant_found && eligible[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Grant is combinational so memory sees the request in the same cycle;
    // suppressed while in reset so nothing launches into a cleared tag pipe.
    assign mem_re       = grant_found & ~RST;
    assign mem_address  = mem_re ? client_address[grant_idx*ADDR_BITS +: ADDR_BITS] : '0;
    assign next_rr      = (grant_idx == TAG_BITS'(N_CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
    assign grant_onehot = mem_re ? ({{(N_CLIENTS-1){1'b0}}, 1'b1} << grant_idx) : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            client_rready <= '0;
            client_data   <= '0;
            pending       <= '0;
            rr_ptr        <= '0;
            pipe_valid    <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            if (mem_re) begin
                rr_ptr <= next_rr;
            end

            // pending drops on the same edge that ends the rready pulse.
            pending <= (pending | grant_onehot) & ~client_rready;

            pipe_valid[0] <= mem_re;
            pipe_tag[0]   <= grant_idx;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end

            // Tail of the tag pipe lines up with valid mem_data.
            client_rready <= '0;
            if (pipe_valid[MEM_LATENCY-1]) begin
                client_rready[pipe_tag[MEM_LATENCY-1]] <= 1'b1;
                client_data                            <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// tb/tb_gfx_mem_arbiter.sv - self-checking bench for gfx_mem_arbiter

module tb_gfx_mem_arbiter;

    localparam int N   = 4;
    localparam int A   = 16;
    localparam int D   = 16;
    localparam int LAT = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic [N*A-1:0]   client_address;
    logic [N-1:0]     client_rvalid;
    logic [N-1:0]     client_rready;
    logic [D-1:0]     client_data;
    logic [A-1:0]     mem_address;
    logic             mem_re;
    logic [D-1:0]     mem_data;

    gfx_mem_arbiter #(
        .N_CLIENTS  (N),
        .ADDR_BITS  (A),
        .DATA_BITS  (D),
        .MEM_LATENCY(LAT)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .client_address(client_address),
        .client_rvalid (client_rvalid),
        .client_rready (client_rready),
        .client_data   (client_data),
        .mem_address   (mem_address),
        .mem_re        (mem_re),
        .mem_data      (mem_data)
    );

    always #5 CLK = ~CLK;

    // Memory model: returns address ^ A5A5, LAT cycles after the request cycle.
    logic [D-1:0] mpipe [LAT];
    always @(posedge CLK) begin
        mpipe[0] <= mem_address ^ 16'hA5A5;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mem_data = mpipe[LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected words pushed when a grant is observed, popped on rready.
    typedef struct {
        int          client;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   glog[$];
    int   rx_cnt [N];
    bit   outst [N];
    int   mk;
    exp_t me;

    initial for (int i = 0; i < N; i++) begin rx_cnt[i] = 0; outst[i] = 0; end

    always @(negedge CLK) begin
        if (RST) begin
            sbq.delete();
            for (int i = 0; i < N; i++) outst[i] = 0;
        end else begin
            if (mem_re) begin
                mk = -1;
                for (int i = 0; i < N; i++)
                    if (client_rvalid[i] && client_address[i*A +: A] == mem_address) mk = i;
                checks++;
                if (mk < 0) begin
                    errors++;
                    $display("FAIL grant_addr actual %h required a requesting client address", mem_address);
                end else begin
                    checks++;
                    if (outst[mk]) begin
                        errors++;
                        $display("FAIL double_grant client %0d actual 2 outstanding required 1", mk);
                    end
                    outst[mk] = 1;
                    sbq.push_back('{mk, client_address[mk*A +: A] ^ 16'hA5A5, cyc + LAT + 1});
                    glog.push_back(mk);
                end
            end
            if (client_rready != '0) begin
                checks++;
                if ($countones(client_rready) != 1) begin
                    errors++;
                    $display("FAIL rready_onehot actual %b required one-hot", client_rready);
                end
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rready actual %b required 0", client_rready);
                end else begin
                    me = sbq.pop_front();
                    if (client_rready != (N'(1) << me.client) || client_data != me.data || cyc != me.due) begin
                        errors++;
                        $display("FAIL sb_return actual rready %b data %h cyc %0d required rready %b data %h cyc %0d",
                                 client_rready, client_data, cyc, N'(1) << me.client, me.data, me.due);
                    end
                    outst[me.client] = 0;
                    rx_cnt[me.client]++;
                end
            end
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL rready_missing client %0d actual none required pulse at cycle %0d",
                         sbq[0].client, sbq[0].due);
                outst[sbq[0].client] = 0;
                void'(sbq.pop_front());
            end
        end
    end

    task automatic set_client(input int k, input logic v, input logic [15:0] a);
        client_rvalid[k]           = v;
        client_address[k*A +: A]   = a;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    typedef struct {
        int          client;
        logic [15:0] addr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vt [6];
    int   base;
    bit   got;

    initial begin
        vt[0] = '{0, 16'h0123, 16'hA486};
        vt[1] = '{1, 16'h0000, 16'hA5A5};
        vt[2] = '{2, 16'hFFFF, 16'h5A5A};
        vt[3] = '{3, 16'hA5A5, 16'h0000};
        vt[4] = '{0, 16'h1234, 16'hB791};
        vt[5] = '{3, 16'h5A5A, 16'hFFFF};

        RST = 1'b1;
        client_rvalid  = '0;
        client_address = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_rready", client_rready, 0);
        chk("reset_data", client_data, 0);
        chk("reset_mem_re", mem_re, 0);
        chk("reset_mem_addr", mem_address, 0);
        @(posedge CLK); #1 RST = 1'b0;

        // Single requests: grant same cycle, pulse LAT+1 cycles later, one cycle wide.
        for (int r = 0; r < 6; r++) begin
            set_client(vt[r].client, 1'b1, vt[r].addr);
            @(negedge CLK);
            chk("vec_mem_re", mem_re, 1);
            chk("vec_mem_addr", mem_address, vt[r].addr);
            @(posedge CLK); #1 set_client(vt[r].client, 1'b0, vt[r].addr);
            @(negedge CLK);
            @(negedge CLK);
            @(negedge CLK);
            chk("vec_rready", client_rready, N'(1) << vt[r].client);
            chk("vec_data", client_data, vt[r].exp_data);
            @(negedge CLK);
            chk("vec_pulse_end", client_rready, 0);
            chk("vec_data_hold", client_data, vt[r].exp_data);
            @(posedge CLK); #1;
        end

        // All clients requesting continuously from reset.
        @(posedge CLK); #1 RST = 1'b1;
        for (int k = 0; k < N; k++) set_client(k, 1'b1, 16'h2000 + 16'(k));
        glog.delete();
        @(posedge CLK); #1 RST = 1'b0;
        idle(40);
        client_rvalid = '0;
        idle(8);
        chk("rr_grant_count", glog.size() >= 8, 1);
        for (int i = 0; i < 8; i++) chk("rr_order", glog[i], i % N);

        // Clients 1 and 3 together with rr_ptr=2.
        do_reset();
        set_client(1, 1'b1, 16'h1111);
        @(posedge CLK); #1 set_client(1, 1'b0, 16'h1111);
        idle(6);
        set_client(1, 1'b1, 16'h1111);
        set_client(3, 1'b1, 16'h3333);
        @(negedge CLK);
        chk("pair_first", mem_address, 16'h3333);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("pair_second", mem_address, 16'h1111);
        @(posedge CLK); #1 client_rvalid = '0;
        idle(6);
        set_client(0, 1'b1, 16'h0A0A);
        set_client(2, 1'b1, 16'h2222);
        @(negedge CLK);
        chk("ptr_after_pair", mem_address, 16'h2222);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("ptr_after_pair_next", mem_address, 16'h0A0A);
        @(posedge CLK); #1 client_rvalid = '0;
        idle(6);

        // Framebuffer fetch loop on client 0 while client 2 stays busy.
        do_reset();
        base = rx_cnt[0];
        set_client(2, 1'b1, 16'hBEEF);
        for (int i = 0; i < 512; i++) begin
            set_client(0, 1'b1, 16'(i));
            got = 0;
            for (int w = 0; w < 20 && !got; w++) begin
                @(negedge CLK);
                if (client_rready[0]) got = 1;
            end
            if (!got) begin
                chk("fb_timeout", 0, 1);
                break;
            end
            @(posedge CLK); #1 set_client(0, 1'b0, 16'(i));
            @(posedge CLK); #1;
        end
        client_rvalid = '0;
        idle(8);
        chk("fb_word_count", rx_cnt[0] - base, 512);

        // Reset with two reads in flight.
        do_reset();
        set_client(0, 1'b1, 16'h5000);
        set_client(1, 1'b1, 16'h5001);
        @(posedge CLK); #1;
        @(posedge CLK); #1 RST = 1'b1; client_rvalid = '0;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_rready", client_rready, 0);
        chk("post_rst_data", client_data, 0);
        chk("post_rst_mem_re", mem_re, 0);
        chk("post_rst_mem_addr", mem_address, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("post_rst_no_rready", client_rready, 0);
        end
        base = rx_cnt[1];
        @(posedge CLK); #1 set_client(1, 1'b1, 16'h5555);
        @(posedge CLK); #1 set_client(1, 1'b0, 16'h5555);
        idle(6);
        chk("post_rst_new_read", rx_cnt[1] - base, 1);

        // Client 0 drops rvalid after grant, then re-requests during its pulse.
        set_client(0, 1'b1, 16'h6000);
        @(negedge CLK);
        chk("drop_grant", mem_re, 1);
        @(posedge CLK); #1 set_client(0, 1'b0, 16'h6000);
        @(posedge CLK); #1 set_client(0, 1'b1, 16'h6001);
        @(negedge CLK);
        chk("drop_pending_block", mem_re, 0);
        @(negedge CLK);
        chk("drop_rready", client_rready, 4'b0001);
        chk("drop_rready_cycle_block", mem_re, 0);
        @(negedge CLK);
        chk("regrant_re", mem_re, 1);
        chk("regrant_addr", mem_address, 16'h6001);
        @(posedge CLK); #1 client_rvalid = '0;
        idle(8);

        chk("sb_drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1);
    end

endmodule
